// File: rtl/spi_master_sd.sv
// ============================================================================
// Module   : spi_master_sd
// Brief    : Single-transaction SPI mode-0 master for the MicroSD path:
//            command byte {RW, addr[6:0]} followed by a write or read byte.
//            Optional macro SPI_LSB_FIRST_EN selects LSB-first bit order.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_master_sd #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       EN,
    input  logic       RW,
    input  logic [7:0] addres,
    input  logic [7:0] dataIN,
    input  logic       MISO,
    output logic [7:0] dataOUT,
    output logic       DONE,
    output logic       MOSI,
    output logic       CS,
    output logic       SCLK
);

    localparam int              c_CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CW-1:0] c_DIV_LAST = c_CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_en_d;
    logic            r_rw;
    logic [c_CW-1:0] r_cnt;
    logic [3:0]      r_bit;
    logic [15:0]     r_sreg;
    logic [7:0]      r_rx;

    logic [7:0]      w_cmd;
    logic [7:0]      w_data;
    logic [15:0]     w_tx;
    logic [7:0]      w_rx_next;
    logic            w_start;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    assign w_cmd   = {RW, addres[6:0]};
    assign w_data  = RW ? 8'hFF : dataIN;
    assign w_start = (r_state == S_IDLE) && EN && !r_en_d;

    // The transmit word is pre-ordered so the shifter always sends bit 15 first.
`ifdef SPI_LSB_FIRST_EN
    assign w_tx      = {bitrev8(w_cmd), bitrev8(w_data)};
    assign w_rx_next = {MISO, r_rx[7:1]};
`else
    assign w_tx      = {w_cmd, w_data};
    assign w_rx_next = {r_rx[6:0], MISO};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_en_d  <= 1'b0;
            r_rw    <= 1'b0;
            r_cnt   <= '0;
            r_bit   <= 4'd0;
            r_sreg  <= 16'h0000;
            r_rx    <= 8'h00;
            dataOUT <= 8'h00;
            DONE    <= 1'b0;
            MOSI    <= 1'b1;
            CS      <= 1'b1;
            SCLK    <= 1'b0;
        end else begin
            r_en_d <= EN;
            DONE   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    CS   <= 1'b1;
                    SCLK <= 1'b0;
                    MOSI <= 1'b1;
                    if (w_start) begin
                        r_sreg  <= w_tx;
                        MOSI    <= w_tx[15];
                        r_rw    <= RW;
                        CS      <= 1'b0;
                        r_cnt   <= '0;
                        r_bit   <= 4'd0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == c_DIV_LAST) begin
                        r_cnt   <= '0;
                        SCLK    <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != c_DIV_LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt <= '0;
                        if (SCLK) begin
                            SCLK <= 1'b0;
                            if (r_bit != 4'd15) begin
                                MOSI   <= r_sreg[14];
                                r_sreg <= {r_sreg[14:0], 1'b0};
                            end
                        end else if (r_bit == 4'd15) begin
                            r_state <= S_HOLD;
                        end else begin
                            // Rising edge of bit r_bit+1; only the data byte is captured.
                            SCLK  <= 1'b1;
                            r_bit <= r_bit + 4'd1;
                            if (r_bit >= 4'd7) begin
                                r_rx <= w_rx_next;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (r_cnt == c_DIV_LAST) begin
                        r_cnt   <= '0;
                        CS      <= 1'b1;
                        MOSI    <= 1'b1;
                        DONE    <= 1'b1;
                        if (r_rw) begin
                            dataOUT <= r_rx;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_master_sd.sv
// ============================================================================
// Module   : tb_spi_master_sd
// Brief    : Directed vector bench for spi_master_sd (CLK_DIV=2 and CLK_DIV=1).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_master_sd;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       EN = 1'b0;
    logic       EN1 = 1'b0;
    logic       RW = 1'b0;
    logic [7:0] addres = 8'h00;
    logic [7:0] dataIN = 8'h00;
    logic       MISO = 1'b0;
    logic       miso1 = 1'b0;
    logic [7:0] dataOUT, dataOUT1;
    logic       DONE, MOSI, CS, SCLK;
    logic       DONE1, MOSI1, CS1, SCLK1;

    always #5 clk = ~clk;

    spi_master_sd #(.CLK_DIV(2)) dut (
        .clk(clk), .reset(reset), .EN(EN), .RW(RW), .addres(addres),
        .dataIN(dataIN), .MISO(MISO), .dataOUT(dataOUT), .DONE(DONE),
        .MOSI(MOSI), .CS(CS), .SCLK(SCLK)
    );

    spi_master_sd #(.CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .EN(EN1), .RW(RW), .addres(addres),
        .dataIN(dataIN), .MISO(miso1), .dataOUT(dataOUT1), .DONE(DONE1),
        .MOSI(MOSI1), .CS(CS1), .SCLK(SCLK1)
    );

    int checks = 0;
    int errors = 0;

    // Pin monitor and slave model for the CLK_DIV=2 instance
    int          rises = 0, cs_low = 0, done_cnt = 0, sclk_bad = 0, base = 0, k = 0;
    logic [15:0] mosi_word = 16'h0;
    logic [7:0]  slave_byte = 8'h00;
    logic [7:0]  done_dout = 8'h00;
    logic        done_cs = 1'b0, done_mosi = 1'b0;
    logic        prev_sclk = 1'b0, prev_cs = 1'b1;

    always @(negedge clk) begin
        if (SCLK && !prev_sclk) begin
            rises++;
            mosi_word = {mosi_word[14:0], MOSI};
        end
        if (SCLK && CS) sclk_bad++;
        if (!CS) cs_low++;
        if (!CS && prev_cs) base = rises;
        if (DONE) begin
            done_cnt++;
            done_dout = dataOUT;
            done_cs   = CS;
            done_mosi = MOSI;
        end
        k = rises - base;
        if (!SCLK) MISO = (k >= 8 && k < 16) ? slave_byte[15-k] : 1'b0;
        prev_sclk = SCLK;
        prev_cs   = CS;
    end

    // Pin monitor for the CLK_DIV=1 instance
    int          rises1 = 0, cs_low1 = 0, done1 = 0, cyc = 0, last_rise = 0, gap1 = 0;
    logic [15:0] mosi1_word = 16'h0;
    logic        prev_sclk1 = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (SCLK1 && !prev_sclk1) begin
            if (rises1 > 0) gap1 = cyc - last_rise;
            last_rise = cyc;
            rises1++;
            mosi1_word = {mosi1_word[14:0], MOSI1};
        end
        if (!CS1) cs_low1++;
        if (DONE1) done1++;
        prev_sclk1 = SCLK1;
    end

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [7:0]  din;
        logic [7:0]  sb;
        logic [15:0] mosi;
        logic [7:0]  dout;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input logic rw, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] sb);
        RW = rw; addres = a; dataIN = d; slave_byte = sb;
        EN = 1'b0;
        tick();
        EN = 1'b1;
        tick();
        EN = 1'b0;
    endtask

    task automatic wait_done(input int b, input int n, input string nm);
        int t = 0;
        while (done_cnt < b + n && t < 3000) begin
            tick();
            t++;
        end
        chk(nm, 32'(done_cnt >= b + n), 32'd1);
    endtask

    initial begin
        int b_r, b_c, b_d, t;

        vecs[0] = '{1'b0, 8'h37, 8'h37, 8'h00, 16'h3737, 8'h00};
        vecs[1] = '{1'b1, 8'h37, 8'h00, 8'hA5, 16'hB7FF, 8'hA5};
        vecs[2] = '{1'b0, 8'hC2, 8'h5A, 8'hFF, 16'h425A, 8'hA5};
        vecs[3] = '{1'b1, 8'h80, 8'h12, 8'h3C, 16'h80FF, 8'h3C};
        vecs[4] = '{1'b1, 8'h7F, 8'h00, 8'h00, 16'hFFFF, 8'h00};
        vecs[5] = '{1'b0, 8'h00, 8'hFF, 8'h81, 16'h00FF, 8'h00};

        repeat (3) tick();
        chk("rst_cs", 32'(CS), 32'd1);
        chk("rst_sclk", 32'(SCLK), 32'd0);
        chk("rst_mosi", 32'(MOSI), 32'd1);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_dout", 32'(dataOUT), 32'h00);
        reset = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 6; i++) begin
            b_r = rises; b_c = cs_low; b_d = done_cnt;
            start(vecs[i].rw, vecs[i].addr, vecs[i].din, vecs[i].sb);
            wait_done(b_d, 1, $sformatf("v%0d_timeout", i));
            repeat (3) tick();
            chk($sformatf("v%0d_mosi", i), 32'(mosi_word), 32'(vecs[i].mosi));
            chk($sformatf("v%0d_rises", i), 32'(rises - b_r), 32'd16);
            chk($sformatf("v%0d_cslow", i), 32'(cs_low - b_c), 32'd68);
            chk($sformatf("v%0d_done", i), 32'(done_cnt - b_d), 32'd1);
            chk($sformatf("v%0d_dout", i), 32'(done_dout), 32'(vecs[i].dout));
        end
        chk("done_cycle_cs", 32'(done_cs), 32'd1);
        chk("done_cycle_mosi", 32'(done_mosi), 32'd1);

        // EN held high for 500 cycles starts exactly one transaction
        b_r = rises; b_d = done_cnt;
        RW = 1'b0; addres = 8'h12; dataIN = 8'h34;
        EN = 1'b0; tick();
        EN = 1'b1;
        repeat (500) tick();
        EN = 1'b0; tick();
        chk("hold_done", 32'(done_cnt - b_d), 32'd1);
        chk("hold_rises", 32'(rises - b_r), 32'd16);
        chk("hold_mosi", 32'(mosi_word), 32'h1234);

        // Back-to-back: new EN edge during the DONE cycle is accepted
        b_d = done_cnt;
        start(1'b1, 8'h05, 8'h00, 8'h5A);
        t = 0;
        while (done_cnt == b_d && t < 300) begin
            tick();
            t++;
        end
        chk("b2b_first_done", 32'(done_cnt - b_d), 32'd1);
        EN = 1'b1; RW = 1'b0; addres = 8'h21; dataIN = 8'h43;
        tick();
        chk("b2b_cs_low", 32'(CS), 32'd0);
        EN = 1'b0;
        wait_done(b_d, 2, "b2b_timeout");
        repeat (3) tick();
        chk("b2b_mosi", 32'(mosi_word), 32'h2143);
        chk("b2b_dout", 32'(dataOUT), 32'h5A);

        // EN edge while busy and mid-transfer input changes are ignored
        b_d = done_cnt;
        RW = 1'b0; addres = 8'h11; dataIN = 8'h22;
        EN = 1'b0; tick();
        EN = 1'b1;
        repeat (10) tick();
        EN = 1'b0; RW = 1'b1; dataIN = 8'h99; addres = 8'h55; slave_byte = 8'hC3;
        repeat (3) tick();
        EN = 1'b1;
        wait_done(b_d, 1, "busy_timeout");
        repeat (100) tick();
        chk("busy_mosi", 32'(mosi_word), 32'h1122);
        chk("busy_done", 32'(done_cnt - b_d), 32'd1);
        chk("busy_dout", 32'(done_dout), 32'h5A);
        EN = 1'b0; tick();

        // Asynchronous reset in the middle of SHIFT
        start(1'b1, 8'h33, 8'h00, 8'hF0);
        repeat (20) tick();
        chk("pre_rst_cs", 32'(CS), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_cs", 32'(CS), 32'd1);
        chk("arst_sclk", 32'(SCLK), 32'd0);
        chk("arst_mosi", 32'(MOSI), 32'd1);
        chk("arst_done", 32'(DONE), 32'd0);
        chk("arst_dout", 32'(dataOUT), 32'h00);
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();

        // CLK_DIV=1 instance
        b_r = rises1; b_c = cs_low1; b_d = done1;
        RW = 1'b0; addres = 8'h4B; dataIN = 8'hC3;
        EN1 = 1'b0; tick();
        EN1 = 1'b1; tick();
        EN1 = 1'b0;
        t = 0;
        while (done1 == b_d && t < 300) begin
            tick();
            t++;
        end
        repeat (2) tick();
        chk("div1_done", 32'(done1 - b_d), 32'd1);
        chk("div1_rises", 32'(rises1 - b_r), 32'd16);
        chk("div1_cslow", 32'(cs_low1 - b_c), 32'd34);
        chk("div1_period", 32'(gap1), 32'd2);
        chk("div1_mosi", 32'(mosi1_word), 32'h4BC3);

        chk("sclk_while_cs_high", 32'(sclk_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
